mux32_read_arbiter: RTL and testbench

Round-robin controller that shares one `mux32` read port among `NUM_REQ` independent requesters. Each requester presents a 5-bit register index with a valid/ready handshake. The arbiter drives the mux `select`, captures the mux output into a register and returns it to the winning requester with its own valid/ready handshake. It sits between the register-file storage (which feeds the 32 mux inputs) and the consumers that need read access.

---
 rtl/mux32_read_arbiter.sv | 114 +++++++++++
 tb/tb_mux32_read_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux32_read_arbiter.sv
// Round-robin arbiter sharing one mux32 read port among NUM_REQ requesters.
// Optional macro MUX32_READ_ARBITER_ZERO_REG_EN hard-wires address 0 to read as zero.
//
// state  | meaning
// IDLE   | arbitrate; accept the round-robin winner and latch its address
// SELECT | mux_select is driven from sel_q; mux_out is captured into data_q
// RESP   | present data_q to the granted requester until it takes it
module mux32_read_arbiter #(
    parameter int N       = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [5*NUM_REQ-1:0]   req_addr,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [4:0]             mux_select,
    input  logic [N-1:0]           mux_out,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [N-1:0]           rsp_data,
    input  logic [NUM_REQ-1:0]     rsp_ready
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [4:0]      sel_q;
    logic [GW-1:0]   gnt_q;
    logic [GW-1:0]   last_grant;
    logic [N-1:0]    data_q;
    logic [GW-1:0]   winner;
    logic            found;
    logic [4:0]      win_addr;
    logic [N-1:0]    capture;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    assign win_addr = req_addr[5*int'(winner) +: 5];

`ifdef MUX32_READ_ARBITER_ZERO_REG_EN
    assign capture = (sel_q == 5'd0) ? '0 : mux_out;
`else
    assign capture = mux_out;
`endif

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    state_nxt         = SELECT;
                end
            end
            SELECT: state_nxt = RESP;
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= '0;
            gnt_q      <= '0;
            data_q     <= '0;
            last_grant <= GW'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        sel_q <= win_addr;
                        gnt_q <= winner;
                    end
                end
                SELECT: data_q <= capture;
                RESP: begin
                    if (rsp_ready[gnt_q]) last_grant <= gnt_q;
                end
                default: ;
            endcase
        end
    end

    assign mux_select = sel_q;
    assign rsp_data   = data_q;

endmodule

// File: tb/tb_mux32_read_arbiter.sv
// Directed bench for mux32_read_arbiter with a behavioural 32-entry mux in front.
module tb_mux32_read_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [19:0] req_addr;
    logic [3:0]  req_ready;
    logic [4:0]  mux_select;
    logic [31:0] mux_out;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_ready;

    logic [31:0] mem [32];
    int checks;
    int errors;

    mux32_read_arbiter #(.N(32), .NUM_REQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .mux_select (mux_select),
        .mux_out    (mux_out),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    assign mux_out = mem[mux_select];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[5*i +: 5] = a;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = '0; req_addr = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp %b", req_ready, 4'b0000); end
        checks++; if (mux_select !== 5'd0) begin errors++; $display("FAIL reset_mux_select got %0d exp 0", mux_select); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_priority got %b exp 0010", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single_read();
        set_addr(0, 5'd5);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_accept got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (mux_select !== 5'd5) begin errors++; $display("FAIL single_select got %0d exp 5", mux_select); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_k1 got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_early got %b exp 0000", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rsp_data got %h exp deadbeef", rsp_data); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_k2 got %b exp 0000", req_ready); end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_done got %b exp 0000", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] oh;
        logic [4:0] a;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << order[g];
            a  = 5'(order[g] + 1);
            #1;
            checks++; if (req_ready !== oh) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", g, req_ready, oh); end
            tick();
            checks++; if (mux_select !== a) begin errors++; $display("FAIL rr_select%0d got %0d exp %0d", g, mux_select, a); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_gap1_%0d got %b exp 0000", g, req_ready); end
            tick();
            checks++; if (rsp_valid !== oh) begin errors++; $display("FAIL rr_rsp_valid%0d got %b exp %b", g, rsp_valid, oh); end
            checks++; if (rsp_data !== mem[a]) begin errors++; $display("FAIL rr_rsp_data%0d got %h exp %h", g, rsp_data, mem[a]); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_gap2_%0d got %b exp 0000", g, req_ready); end
            tick();
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        logic [31:0] saved;
        logic [31:0] exp_data;
        // last grant is 0, so requester 1 wins ahead of requester 2
        set_addr(1, 5'd7);
        set_addr(2, 5'd8);
        saved = mem[7];
        exp_data = mem[7];
        req_valid = 4'b0110;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_grant got %b exp 0010", req_ready); end
        tick(); tick();
        rsp_ready = 4'b1101;
        for (int c = 0; c < 10; c++) begin
            mem[7] = 32'h5A5A0000 + 32'(c);
            #1;
            checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_hold_valid%0d got %b exp 0010", c, rsp_valid); end
            checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL bp_hold_data%0d got %h exp %h", c, rsp_data, exp_data); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req2_wait%0d got %b exp 0000", c, req_ready); end
            tick();
        end
        mem[7] = saved;
        rsp_ready = 4'b0010;
        tick();
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_req2_grant got %b exp 0100", req_ready); end
        tick(); tick();
        checks++; if (rsp_data !== mem[8]) begin errors++; $display("FAIL bp_req2_data got %h exp %h", rsp_data, mem[8]); end
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        // last grant is 2, so a lone requester 3 is accepted
        set_addr(3, 5'd9);
        set_addr(0, 5'd11);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_grant3 got %b exp 1000", req_ready); end
        tick();
        checks++; if (mux_select !== 5'd9) begin errors++; $display("FAIL mid_select got %0d exp 9", mux_select); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_valid got %b exp 0000", rsp_valid); end
        checks++; if (mux_select !== 5'd0) begin errors++; $display("FAIL mid_mux_select got %0d exp 0", mux_select); end
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_next_grant got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_data !== mem[11]) begin errors++; $display("FAIL mid_rsp_data got %h exp %h", rsp_data, mem[11]); end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_zero_reg();
        logic [31:0] exp_data;
`ifdef MUX32_READ_ARBITER_ZERO_REG_EN
        exp_data = 32'h0;
`else
        exp_data = 32'h12345678;
`endif
        set_addr(2, 5'd0);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL zero_grant got %b exp 0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (mux_select !== 5'd0) begin errors++; $display("FAIL zero_select got %0d exp 0", mux_select); end
        tick();
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL zero_rsp_valid got %b exp 0100", rsp_valid); end
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL zero_rsp_data got %h exp %h", rsp_data, exp_data); end
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_withdrawn();
        // last grant is 2: requester 0 first, then 1 withdraws and 2 should follow
        set_addr(0, 5'd12);
        set_addr(1, 5'd20);
        set_addr(2, 5'd13);
        req_valid = 4'b0111;
        rsp_ready = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wd_first got %b exp 0001", req_ready); end
        tick();
        req_valid = 4'b0101;
        tick();
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL wd_rsp0 got %b exp 0001", rsp_valid); end
        checks++; if (rsp_data !== mem[12]) begin errors++; $display("FAIL wd_data0 got %h exp %h", rsp_data, mem[12]); end
        tick();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wd_skip got %b exp 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (mux_select !== 5'd13) begin errors++; $display("FAIL wd_select got %0d exp 13", mux_select); end
        tick();
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL wd_rsp2 got %b exp 0100", rsp_valid); end
        checks++; if (rsp_data !== mem[13]) begin errors++; $display("FAIL wd_data2 got %h exp %h", rsp_data, mem[13]); end
        tick();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL wd_no_rsp1 got %b exp 0000", rsp_valid); end
        rsp_ready = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA5000000 + 32'(i) * 32'h00010101;
        mem[0] = 32'h12345678;
        mem[5] = 32'hDEADBEEF;
        rst = 1'b1; req_valid = '0; req_addr = '0; rsp_ready = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_zero_reg();
        test_withdrawn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
